// File: rtl/int_res_mem_arbiter.sv
// Round-robin arbiter between the EEG loader (req 0) and the compute engine (req 1)
// for the banked intermediate-result memory; double-width accesses become word pairs.
module int_res_mem_arbiter #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 14336
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [1:0]                 we,
  input  logic [1:0]                 width,
  input  logic [1:0][15:0]           addr,
  input  logic [1:0][29:0]           wdata,
  output logic [1:0]                 gnt,
  output logic [1:0]                 err,
  output logic [1:0]                 rvalid,
  output logic [29:0]                rdata,
  output logic [NUM_BANKS-1:0]       bank_en,
  output logic                       bank_we,
  output logic [13:0]                bank_addr,
  output logic [14:0]                bank_wdata,
  input  logic [NUM_BANKS-1:0][14:0] bank_rdata
);

  localparam int          BSEL_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int          BADDR_W     = 14;
  localparam logic [16:0] TOTAL_WORDS = 17'(NUM_BANKS * BANK_WORDS);

  typedef enum logic {SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1} width_e;
  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_e;

  // Bank index from threshold compares against multiples of BANK_WORDS.
  function automatic logic [BSEL_W-1:0] bank_of(input logic [16:0] a);
    logic [BSEL_W-1:0] b;
    b = '0;
    for (int k = 1; k < NUM_BANKS; k++) begin
      if (a >= 17'(k * BANK_WORDS)) b = BSEL_W'(k);
    end
    return b;
  endfunction

  function automatic logic [BADDR_W-1:0] local_of(input logic [16:0] a,
                                                  input logic [BSEL_W-1:0] b);
    return BADDR_W'(a - 17'(b) * 17'(BANK_WORDS));
  endfunction

  state_e               state_q, state_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  width_e               width_q, width_d;
  logic [14:0]          hi_word_q, hi_word_d;
  logic [BSEL_W-1:0]    lo_bank_q, lo_bank_d;
  logic [BSEL_W-1:0]    hi_bank_q, hi_bank_d;
  logic [BADDR_W-1:0]   hi_addr_q, hi_addr_d;
  logic [14:0]          lo_word_q, lo_word_d;
  logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;
  logic                 bank_we_q, bank_we_d;
  logic [BADDR_W-1:0]   bank_addr_q, bank_addr_d;
  logic [14:0]          bank_wdata_q, bank_wdata_d;

  logic                 win;
  logic [16:0]          lo_flat, hi_flat;
  logic [BSEL_W-1:0]    lo_bank, hi_bank;
  logic [BADDR_W-1:0]   lo_local, hi_local;
  logic                 out_of_range;
  logic [NUM_BANKS-1:0] lo_sel, hi_sel;
  logic [14:0]          sel_lo_rdata;

  // With both requesting, the one not granted last wins.
  always_comb begin
    if (req == 2'b11) win = ~last_gnt_q;
    else              win = req[1];
  end

  assign lo_flat      = {1'b0, addr[win]};
  assign hi_flat      = lo_flat + 17'd1;
  assign lo_bank      = bank_of(lo_flat);
  assign hi_bank      = bank_of(hi_flat);
  assign lo_local     = local_of(lo_flat, lo_bank);
  assign hi_local     = local_of(hi_flat, hi_bank);
  assign out_of_range = (lo_flat >= TOTAL_WORDS) ||
                        ((width[win] == DOUBLE_WIDTH) && (hi_flat >= TOTAL_WORDS));

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_sel
    assign lo_sel[gi] = (lo_bank == BSEL_W'(gi));
    assign hi_sel[gi] = (hi_bank_q == BSEL_W'(gi));
  end

  assign sel_lo_rdata = bank_rdata[lo_bank_q];

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    width_d      = width_q;
    hi_word_d    = hi_word_q;
    lo_bank_d    = lo_bank_q;
    hi_bank_d    = hi_bank_q;
    hi_addr_d    = hi_addr_q;
    lo_word_d    = lo_word_q;
    bank_en_d    = '0;
    bank_we_d    = 1'b0;
    bank_addr_d  = '0;
    bank_wdata_d = '0;
    gnt          = '0;
    err          = '0;
    rvalid       = '0;
    rdata        = '0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt[win]   = 1'b1;
          last_gnt_d = win;
          if (out_of_range) begin
            err[win] = 1'b1;
          end else begin
            state_d      = ACC_LO;
            owner_d      = win;
            we_d         = we[win];
            width_d      = width_e'(width[win]);
            hi_word_d    = wdata[win][29:15];
            lo_bank_d    = lo_bank;
            hi_bank_d    = hi_bank;
            hi_addr_d    = hi_local;
            bank_en_d    = lo_sel;
            bank_we_d    = we[win];
            bank_addr_d  = lo_local;
            bank_wdata_d = we[win] ? wdata[win][14:0] : 15'd0;
          end
        end
      end
      ACC_LO: begin
        if (width_q == DOUBLE_WIDTH) begin
          state_d      = ACC_HI;
          bank_en_d    = hi_sel;
          bank_we_d    = we_q;
          bank_addr_d  = hi_addr_q;
          bank_wdata_d = we_q ? hi_word_q : 15'd0;
        end else begin
          state_d = we_q ? IDLE : RESP;
        end
      end
      ACC_HI: begin
        // Low word from the ACC_LO command is on the bank bus now.
        if (!we_q) lo_word_d = sel_lo_rdata;
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        rvalid[owner_q] = 1'b1;
        if (width_q == DOUBLE_WIDTH) rdata = {bank_rdata[hi_bank_q], lo_word_q};
        else                         rdata = {{15{sel_lo_rdata[14]}}, sel_lo_rdata};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      gnt    = '0;
      err    = '0;
      rvalid = '0;
      rdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      width_q      <= SINGLE_WIDTH;
      hi_word_q    <= '0;
      lo_bank_q    <= '0;
      hi_bank_q    <= '0;
      hi_addr_q    <= '0;
      lo_word_q    <= '0;
      bank_en_q    <= '0;
      bank_we_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      width_q      <= width_d;
      hi_word_q    <= hi_word_d;
      lo_bank_q    <= lo_bank_d;
      hi_bank_q    <= hi_bank_d;
      hi_addr_q    <= hi_addr_d;
      lo_word_q    <= lo_word_d;
      bank_en_q    <= bank_en_d;
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
    end
  end

  assign bank_en    = bank_en_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;

endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Directed bench for int_res_mem_arbiter: vector table plus contention,
// error-turnaround and mid-transaction reset sequences against a bank memory model.
module tb_int_res_mem_arbiter;

  localparam int NB = 4;
  localparam int BW = 14336;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, we, width;
  logic [1:0][15:0] addr;
  logic [1:0][29:0] wdata;
  logic [1:0]       gnt, err, rvalid;
  logic [29:0]      rdata;
  logic [NB-1:0]    bank_en;
  logic             bank_we;
  logic [13:0]      bank_addr;
  logic [14:0]      bank_wdata;
  logic [NB-1:0][14:0] bank_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  int_res_mem_arbiter #(.NUM_BANKS(NB), .BANK_WORDS(BW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .width(width), .addr(addr),
    .wdata(wdata), .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  // Bank macro model: registered read one cycle after the enable.
  logic [14:0] mem [NB][BW];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we) mem[b][bank_addr] <= bank_wdata;
        else         bank_rdata[b] <= mem[b][bank_addr];
      end
    end
  end

  typedef struct {
    logic        r;
    logic        w;
    logic        dbl;
    logic [15:0] a;
    logic [29:0] wd;
    logic        e;
    logic [3:0]  en0;
    logic [13:0] ad0;
    logic [14:0] wd0;
    logic [3:0]  en1;
    logic [13:0] ad1;
    logic [14:0] wd1;
    logic [29:0] rd;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(input logic r, input logic w, input logic dbl, input int a,
                              input logic [29:0] wd, input logic e, input logic [3:0] en0,
                              input int ad0, input logic [14:0] wd0, input logic [3:0] en1,
                              input int ad1, input logic [14:0] wd1, input logic [29:0] rd);
    vec_t v;
    v.r = r; v.w = w; v.dbl = dbl; v.a = 16'(a); v.wd = wd; v.e = e;
    v.en0 = en0; v.ad0 = 14'(ad0); v.wd0 = wd0;
    v.en1 = en1; v.ad1 = 14'(ad1); v.wd1 = wd1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", nm, act);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] oh;
    oh = 2'b01 << v.r;
    @(negedge clk);
    req = oh; we[v.r] = v.w; width[v.r] = v.dbl; addr[v.r] = v.a; wdata[v.r] = v.wd;
    #1;
    chk($sformatf("v%0d gnt", idx), 32'(gnt), 32'(oh));
    chk($sformatf("v%0d err", idx), 32'(err), v.e ? 32'(oh) : 32'd0);
    @(negedge clk);
    req = '0;
    #1;
    if (v.e) begin
      chk($sformatf("v%0d err bank_en", idx), 32'(bank_en), 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d err rvalid", idx), 32'(rvalid), 32'd0);
    end else begin
      chk($sformatf("v%0d lo en", idx), 32'(bank_en), 32'(v.en0));
      chk($sformatf("v%0d lo addr", idx), 32'(bank_addr), 32'(v.ad0));
      chk($sformatf("v%0d lo we", idx), 32'(bank_we), 32'(v.w));
      if (v.w) chk($sformatf("v%0d lo wdata", idx), 32'(bank_wdata), 32'(v.wd0));
      if (v.dbl) begin
        @(negedge clk);
        #1;
        chk($sformatf("v%0d hi en", idx), 32'(bank_en), 32'(v.en1));
        chk($sformatf("v%0d hi addr", idx), 32'(bank_addr), 32'(v.ad1));
        if (v.w) chk($sformatf("v%0d hi wdata", idx), 32'(bank_wdata), 32'(v.wd1));
      end
      if (!v.w) begin
        @(negedge clk);
        #1;
        chk($sformatf("v%0d rvalid", idx), 32'(rvalid), 32'(oh));
        chk($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.rd));
        chk($sformatf("v%0d resp bank_en", idx), 32'(bank_en), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    logic last_r;
    rst = 1'b1; req = '0; we = '0; width = '0; addr = '0; wdata = '0;

    //            r  w  d  addr   wdata         e  en0 ad0    wd0     en1 ad1    wd1     rdata
    vt[0]  = mk(0, 1, 0, 5,     30'h0000_1ABC, 0, 1, 5,     15'h1ABC, 0, 0,     0,        30'h0);
    vt[1]  = mk(1, 0, 0, 5,     30'h0,         0, 1, 5,     0,        0, 0,     0,        30'h0000_1ABC);
    vt[2]  = mk(0, 1, 0, 6,     30'h0000_4ABC, 0, 1, 6,     15'h4ABC, 0, 0,     0,        30'h0);
    vt[3]  = mk(1, 0, 0, 6,     30'h0,         0, 1, 6,     0,        0, 0,     0,        30'h3FFF_CABC);
    vt[4]  = mk(0, 1, 1, 14335, 30'h2AAA_5555, 0, 1, 14335, 15'h5555, 2, 0,     15'h5554, 30'h0);
    vt[5]  = mk(1, 0, 1, 14335, 30'h0,         0, 1, 14335, 0,        2, 0,     0,        30'h2AAA_5555);
    vt[6]  = mk(1, 1, 0, 43008, 30'h0000_0123, 0, 8, 0,     15'h0123, 0, 0,     0,        30'h0);
    vt[7]  = mk(0, 0, 0, 43008, 30'h0,         0, 8, 0,     0,        0, 0,     0,        30'h0000_0123);
    vt[8]  = mk(0, 1, 1, 57342, 30'h1234_5678, 0, 8, 14334, 15'h5678, 8, 14335, 15'h2468, 30'h0);
    vt[9]  = mk(1, 0, 1, 57342, 30'h0,         0, 8, 14334, 0,        8, 14335, 0,        30'h1234_5678);
    vt[10] = mk(1, 0, 0, 57343, 30'h0,         0, 8, 14335, 0,        0, 0,     0,        30'h0000_2468);
    vt[11] = mk(0, 1, 0, 28671, 30'h0000_7FFF, 0, 2, 14335, 15'h7FFF, 0, 0,     0,        30'h0);
    vt[12] = mk(1, 1, 0, 28672, 30'h0000_0055, 0, 4, 0,     15'h0055, 0, 0,     0,        30'h0);
    vt[13] = mk(0, 0, 1, 28671, 30'h0,         0, 2, 14335, 0,        4, 0,     0,        30'h002A_FFFF);
    vt[14] = mk(1, 0, 0, 28671, 30'h0,         0, 2, 14335, 0,        0, 0,     0,        30'h3FFF_FFFF);
    vt[15] = mk(0, 0, 0, 57344, 30'h0,         1, 0, 0,     0,        0, 0,     0,        30'h0);
    vt[16] = mk(1, 0, 1, 57343, 30'h0,         1, 0, 0,     0,        0, 0,     0,        30'h0);
    vt[17] = mk(0, 0, 0, 65535, 30'h0,         1, 0, 0,     0,        0, 0,     0,        30'h0);

    // Reset state
    repeat (3) @(negedge clk);
    req = 2'b11;
    #1;
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst rdata", 32'(rdata), 32'd0);
    chk("rst bank_en", 32'(bank_en), 32'd0);
    chk("rst bank_we", 32'(bank_we), 32'd0);
    chk("rst bank_addr", 32'(bank_addr), 32'd0);
    chk("rst bank_wdata", 32'(bank_wdata), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(vt[i], i);

    // Error turnaround: a rejected request frees the arbiter for the very next cycle.
    @(negedge clk);
    req = 2'b01; we[0] = 1'b0; width[0] = 1'b0; addr[0] = 16'd57344;
    #1;
    chk("errturn gnt0", 32'(gnt), 32'd1);
    chk("errturn err0", 32'(err), 32'd1);
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 16'd7; wdata[0] = 30'h11;
    #1;
    chk("errturn gnt1", 32'(gnt), 32'd1);
    chk("errturn err1", 32'(err), 32'd0);
    chk("errturn bank_en idle", 32'(bank_en), 32'd0);
    @(negedge clk);
    req = '0;
    #1;
    chk("errturn bank_en", 32'(bank_en), 32'd1);
    chk("errturn bank_addr", 32'(bank_addr), 32'd7);

    // Contention from a fresh reset: grants alternate starting with requester 0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    we = 2'b11; width = 2'b00; addr[0] = 16'd100; addr[1] = 16'd200;
    wdata[0] = 30'h11; wdata[1] = 30'h22; req = 2'b11;
    ngr = 0;
    last_r = 1'b0;
    for (int c = 0; c < 40 && ngr < 6; c++) begin
      #1;
      if (gnt != 2'b00) begin
        chk($sformatf("rr gnt #%0d", ngr), 32'(gnt), (ngr % 2 == 0) ? 32'd1 : 32'd2);
        chk($sformatf("rr no overlap #%0d", ngr), 32'(bank_en), 32'd0);
        last_r = gnt[1];
        ngr++;
      end else if (ngr > 0) begin
        chk($sformatf("rr bank_addr after #%0d", ngr - 1), 32'(bank_addr),
            last_r ? 32'd200 : 32'd100);
      end
      @(negedge clk);
    end
    req = '0;
    chk("rr grant count", 32'(ngr), 32'd6);
    #1;
    chk("rr last bank_addr", 32'(bank_addr), 32'd200);

    // Reset during ACC_HI of a double read.
    @(negedge clk);
    req = 2'b01; we[0] = 1'b0; width[0] = 1'b1; addr[0] = 16'd14335;
    #1;
    chk("rstmid gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    req = '0;
    #1;
    chk("rstmid lo en", 32'(bank_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid hi en", 32'(bank_en), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid bank_en cleared", 32'(bank_en), 32'd0);
    chk("rstmid rvalid c3", 32'(rvalid), 32'd0);
    @(negedge clk);
    we = 2'b11; width = 2'b00; addr[0] = 16'd10; addr[1] = 16'd11; req = 2'b11;
    #1;
    chk("rstmid rvalid c4", 32'(rvalid), 32'd0);
    chk("rstmid contested gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
